// File: rtl/cc_pkg.sv
// Shared types for the condition-code branch unit: condition selectors, FSM states, flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cc_pkg;

    // Branch condition selectors, ARM-style encoding.
    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    // Request accept -> evaluate -> hold result until consumed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bit positions inside the packed {N,Z,V,C} flags word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/cc_branch_unit_cond_eval.sv
// Combinational condition evaluator: {N,Z,V,C} flags plus a condition selector -> taken.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module cond_eval
    import cc_pkg::*;
(
    input  logic [3:0] flags,
    input  cond_e      cond,
    output logic       taken
);

    logic n;
    logic z;
    logic v;
    logic c;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign c = flags[FLAG_C];

    // Decode the selector; C=1 means "no borrow", so HI/LS are unsigned compares after x-y.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c && !z;
            COND_LS: taken = !c || z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = z || (n != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_branch_unit.sv
// Branch unit: holds condition flags, evaluates a branch condition and produces the next PC.
// Latency: accept at edge T, result valid from edge T+1; at most one branch per 3 cycles.
// Backpressure: br_ready only in IDLE; result held stable until res_ready.
module cc_branch_unit
    import cc_pkg::*;
#(
    parameter int nBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ccn,
    input  logic             ccz,
    input  logic             ccv,
    input  logic             ccc,
    input  logic             cc_we,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [3:0]       br_cond,
    input  logic [nBITS-1:0] br_pc,
    input  logic [nBITS-1:0] br_offset,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [nBITS-1:0] res_pc,
    output logic [3:0]       flags
);

    localparam logic [nBITS-1:0] PC_STEP = {{(nBITS-1){1'b0}}, 1'b1};

    state_e           state_q,     state_d;
    logic [3:0]       flags_q,     flags_d;
    cond_e            cond_q,      cond_d;
    logic [nBITS-1:0] pc_q,        pc_d;
    logic [nBITS-1:0] off_q,       off_d;
    logic             res_taken_q, res_taken_d;
    logic [nBITS-1:0] res_pc_q,    res_pc_d;
    logic             br_ready_q,  br_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             cond_taken;

    // Evaluates the captured condition against the flags as they stand this cycle.
    cond_eval u_cond_eval (
        .flags (flags_q),
        .cond  (cond_q),
        .taken (cond_taken)
    );

    // Next-state logic: flags load in every state; FSM walks IDLE -> EVAL -> RESP -> IDLE.
    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        cond_d      = cond_q;
        pc_d        = pc_q;
        off_d       = off_q;
        res_taken_d = res_taken_q;
        res_pc_d    = res_pc_q;
        br_ready_d  = br_ready_q;
        res_valid_d = res_valid_q;

        if (cc_we) begin
            flags_d = {ccn, ccz, ccv, ccc};
        end

        case (state_q)
            ST_IDLE: begin
                // br_ready_q is high exactly in IDLE, so this is the accept handshake.
                if (br_valid && br_ready_q) begin
                    cond_d     = cond_e'(br_cond);
                    pc_d       = br_pc;
                    off_d      = br_offset;
                    br_ready_d = 1'b0;
                    state_d    = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // flags_q here already includes any load from the accept cycle; a load
                // during EVAL lands on the same edge and so cannot affect this result.
                res_taken_d = cond_taken;
                res_pc_d    = cond_taken ? (pc_q + off_q) : (pc_q + PC_STEP);
                res_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    br_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                br_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over flag loads and handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            flags_q     <= 4'b0000;
            cond_q      <= COND_EQ;
            pc_q        <= '0;
            off_q       <= '0;
            res_taken_q <= 1'b0;
            res_pc_q    <= '0;
            br_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            cond_q      <= cond_d;
            pc_q        <= pc_d;
            off_q       <= off_d;
            res_taken_q <= res_taken_d;
            res_pc_q    <= res_pc_d;
            br_ready_q  <= br_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign br_ready  = br_ready_q;
    assign res_valid = res_valid_q;
    assign res_taken = res_taken_q;
    assign res_pc    = res_pc_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Testbench for cc_branch_unit: directed scenarios plus randomized branches against a reference model.
// Latency: expects result one edge after the EVAL entry (two cycles after accept cycle).
// Backpressure: exercises res_ready stalls and ignored br_valid outside IDLE.
module tb_cc_branch_unit;

    logic       clk;
    logic       reset;
    logic       ccn, ccz, ccv, ccc;
    logic       cc_we;
    logic       br_valid;
    logic       br_ready;
    logic [3:0] br_cond;
    logic [7:0] br_pc;
    logic [7:0] br_offset;
    logic       res_valid;
    logic       res_ready;
    logic       res_taken;
    logic [7:0] res_pc;
    logic [3:0] flags;

    int total;
    int bad;

    // Reference flags {N,Z,V,C} as the model believes them to be.
    logic [3:0] mflags;

    cc_branch_unit #(.nBITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ccn       (ccn),
        .ccz       (ccz),
        .ccv       (ccv),
        .ccc       (ccc),
        .cc_we     (cc_we),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .br_pc     (br_pc),
        .br_offset (br_offset),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_taken (res_taken),
        .res_pc    (res_pc),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Flags an 8-bit subtractor would produce for x - y.
    function automatic logic [3:0] sub_flags(input int x, input int y);
        int  r;
        bit  n, z, v, c;
        r = (x - y + 256) % 256;
        n = (r >= 128);
        z = (r == 0);
        c = (x >= y);
        v = ((x >= 128) != (y >= 128)) && ((r >= 128) != (x >= 128));
        return {n, z, v, c};
    endfunction

    // Condition truth from the textual rules.
    function automatic bit model_taken(input int cond, input logic [3:0] f);
        bit n, z, v, c;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        case (cond)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_pc(input bit tk, input int pc, input int off);
        return tk ? (pc + off) % 256 : (pc + 1) % 256;
    endfunction

    // Load flags from a subtraction x - y via cc_we for one cycle.
    task automatic set_flags(input int x, input int y);
        logic [3:0] f;
        f = sub_flags(x, y);
        {ccn, ccz, ccv, ccc} = f;
        cc_we = 1'b1;
        cyc();
        cc_we = 1'b0;
        mflags = f;
    endtask

    // Issue one branch, hold res_ready low for 'hold' cycles in RESP, then consume.
    task automatic do_branch(input int cond, input int pc, input int off, input int hold,
                             output bit tk, output int rp, output int lat);
        int w;
        w = 0;
        while (!br_ready && w < 20) begin
            cyc();
            w++;
        end
        if (!br_ready) begin
            bad++;
            total++;
            $display("FAIL br_ready_timeout: br_ready=%0b required 1", br_ready);
        end
        br_valid  = 1'b1;
        br_cond   = 4'(cond);
        br_pc     = 8'(pc);
        br_offset = 8'(off);
        cyc();
        br_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 10) begin
            cyc();
            lat++;
        end
        tk = res_taken;
        rp = int'(res_pc);
        for (int i = 0; i < hold; i++) cyc();
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        mflags = 4'b0000;
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
        total++; if (br_ready !== 1'b1) begin bad++; $display("FAIL reset_br_ready: got %b want 1", br_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        total++; if (res_pc !== 8'h00 || res_taken !== 1'b0) begin
            bad++; $display("FAIL reset_res: got pc=%h taken=%b want 00/0", res_pc, res_taken);
        end
    endtask

    task automatic test_eq_not_taken();
        bit tk; int rp; int lat;
        do_branch(0, 8'h10, 8'h05, 0, tk, rp, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL latency: got %0d edges after accept want 1", lat); end
        total++; if (tk !== 1'b0) begin bad++; $display("FAIL eq_nt_taken: got %b want 0", tk); end
        total++; if (rp !== 'h11) begin bad++; $display("FAIL eq_nt_pc: got %h want 11", rp); end
    endtask

    task automatic test_wrap();
        bit tk; int rp; int lat;
        set_flags(5, 5);
        total++; if (flags !== 4'b0101) begin bad++; $display("FAIL flags_5m5: got %b want 0101", flags); end
        do_branch(0, 8'hFE, 8'h04, 0, tk, rp, lat);
        total++; if (tk !== 1'b1) begin bad++; $display("FAIL wrap_taken: got %b want 1", tk); end
        total++; if (rp !== 'h02) begin bad++; $display("FAIL wrap_pc: got %h want 02", rp); end
    endtask

    task automatic test_signed_unsigned();
        bit tk; int rp; int lat;
        set_flags(8'h80, 8'h01);
        do_branch(11, 8'h20, 8'h08, 0, tk, rp, lat);
        total++; if (tk !== 1'b1 || rp !== 'h28) begin
            bad++; $display("FAIL lt_overflow: got taken=%b pc=%h want 1/28", tk, rp);
        end
        do_branch(10, 8'h20, 8'h08, 0, tk, rp, lat);
        total++; if (tk !== 1'b0 || rp !== 'h21) begin
            bad++; $display("FAIL ge_overflow: got taken=%b pc=%h want 0/21", tk, rp);
        end
        set_flags(3, 5);
        do_branch(8, 8'h40, 8'hF0, 0, tk, rp, lat);
        total++; if (tk !== 1'b0 || rp !== 'h41) begin
            bad++; $display("FAIL hi_borrow: got taken=%b pc=%h want 0/41", tk, rp);
        end
    endtask

    task automatic test_flag_timing();
        // Z=1 loaded in the accept cycle, Z=0 loaded during EVAL.
        br_valid = 1'b1; br_cond = 4'd0; br_pc = 8'h30; br_offset = 8'h10;
        {ccn, ccz, ccv, ccc} = 4'b0100;
        cc_we = 1'b1;
        cyc();
        br_valid = 1'b0;
        {ccn, ccz, ccv, ccc} = 4'b0000;
        cyc();
        cc_we = 1'b0;
        mflags = 4'b0000;
        total++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_pc !== 8'h40) begin
            bad++; $display("FAIL flag_timing: got vld=%b taken=%b pc=%h want 1/1/40", res_valid, res_taken, res_pc);
        end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL flag_timing_flags: got %b want 0000", flags); end
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
    endtask

    task automatic test_stall();
        bit exp_tk; int exp_pc; int w;
        set_flags(9, 2);
        exp_tk = model_taken(12, mflags);
        exp_pc = model_pc(exp_tk, 8'hF8, 8'h7F);
        br_valid = 1'b1; br_cond = 4'd12; br_pc = 8'hF8; br_offset = 8'h7F;
        cyc();
        // Keep a different request asserted while busy; it must be ignored.
        br_cond = 4'd15; br_pc = 8'h55;
        w = 0;
        while (!res_valid && w < 10) begin cyc(); w++; end
        for (int i = 0; i < 4; i++) begin
            total++; if (res_valid !== 1'b1 || res_taken !== exp_tk || int'(res_pc) !== exp_pc || br_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got vld=%b taken=%b pc=%h rdy=%b want 1/%b/%h/0",
                         i, res_valid, res_taken, res_pc, br_ready, exp_tk, exp_pc);
            end
            cyc();
        end
        br_valid = 1'b0;
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        total++; if (br_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++; $display("FAIL stall_release: got rdy=%b vld=%b want 1/0", br_ready, res_valid);
        end
        cyc();
        total++; if (br_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++; $display("FAIL ignored_request: got rdy=%b vld=%b want 1/0", br_ready, res_valid);
        end
    endtask

    task automatic test_reset_midflight();
        for (int s = 0; s < 2; s++) begin
            set_flags(5, 5);
            br_valid = 1'b1; br_cond = 4'd14; br_pc = 8'h01; br_offset = 8'h01;
            cyc();
            br_valid = 1'b0;
            if (s == 1) cyc();
            // Reset concurrently with a flag load and a ready consumer.
            reset = 1'b1; cc_we = 1'b1; {ccn, ccz, ccv, ccc} = 4'b1111; res_ready = 1'b1;
            cyc();
            reset = 1'b0; cc_we = 1'b0; res_ready = 1'b0;
            mflags = 4'b0000;
            total++; if (res_valid !== 1'b0 || flags !== 4'b0000 || br_ready !== 1'b1) begin
                bad++; $display("FAIL reset_in_%s: got vld=%b flags=%b rdy=%b want 0/0000/1",
                                (s == 0) ? "eval" : "resp", res_valid, flags, br_ready);
            end
            for (int i = 0; i < 3; i++) begin
                cyc();
                total++; if (res_valid !== 1'b0) begin
                    bad++; $display("FAIL reset_no_result[%0d]: got vld=%b want 0", i, res_valid);
                end
            end
        end
    endtask

    task automatic test_random();
        bit tk; int rp; int lat;
        int x, y, cond, pc, off, hold;
        bit exp_tk; int exp_pc;
        for (int k = 0; k < 40; k++) begin
            x = $urandom_range(0, 255);
            y = ($urandom_range(0, 3) == 0) ? x : $urandom_range(0, 255);
            set_flags(x, y);
            cond = $urandom_range(0, 15);
            pc   = $urandom_range(0, 255);
            off  = $urandom_range(0, 255);
            hold = $urandom_range(0, 2);
            exp_tk = model_taken(cond, mflags);
            exp_pc = model_pc(exp_tk, pc, off);
            do_branch(cond, pc, off, hold, tk, rp, lat);
            total++; if (tk !== exp_tk || rp !== exp_pc || lat !== 1) begin
                bad++;
                $display("FAIL rand[%0d] x=%h y=%h cond=%0d pc=%h off=%h: got taken=%b pc=%h lat=%0d want %b/%h/1",
                         k, x, y, cond, pc, off, tk, rp, lat, exp_tk, exp_pc);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; mflags = 4'b0000;
        reset = 1'b1; cc_we = 1'b0; {ccn, ccz, ccv, ccc} = 4'b0000;
        br_valid = 1'b0; br_cond = 4'd0; br_pc = 8'h00; br_offset = 8'h00;
        res_ready = 1'b0;
        test_reset();
        test_eq_not_taken();
        test_wrap();
        test_signed_unsigned();
        test_flag_timing();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cc_branch_unit.md
CC_BRANCH_UNIT -- requirements
Module: cc_branch_unit

Interface
REQ-001 The block SHALL have parameter nBITS, default 8, giving the width of the PC and branch offset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports ccn, ccz, ccv, ccc, input, 1 bit each: condition codes from the adder/subtractor.
REQ-005 The block SHALL have port cc_we, input, 1 bit: loads ccn/ccz/ccv/ccc into the flags register.
REQ-006 The block SHALL have port br_valid, input, 1 bit: a branch request is present.
REQ-007 The block SHALL have port br_ready, output, 1 bit: the block accepts a request.
REQ-008 The block SHALL have port br_cond, input, 4 bits: condition selector.
REQ-009 The block SHALL have port br_pc, input, nBITS: PC of the branch.
REQ-010 The block SHALL have port br_offset, input, nBITS: two's-complement displacement.
REQ-011 The block SHALL have port res_valid, output, 1 bit: a result is presented.
REQ-012 The block SHALL have port res_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port res_taken, output, 1 bit: the condition held.
REQ-014 The block SHALL have port res_pc, output, nBITS: next PC.
REQ-015 The block SHALL have port flags, output, 4 bits: registered {N,Z,V,C}.

Function
REQ-016 The flags register SHALL load {ccn,ccz,ccv,ccc} at each edge where cc_we=1, and hold otherwise, in every FSM state.
REQ-017 The FSM SHALL have three states: IDLE, EVAL and RESP.
REQ-018 br_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted on an edge where br_valid=1 and br_ready=1; the block then captures br_cond, br_pc and br_offset, and the FSM moves IDLE->EVAL.
REQ-020 In EVAL, the block SHALL evaluate the captured condition against the flags register as it stands at the start of EVAL; a cc_we in the accept cycle is therefore visible, and a cc_we during EVAL or RESP does not affect this result.
REQ-021 EVAL SHALL register res_taken and res_pc, and the FSM SHALL move EVAL->RESP unconditionally.
REQ-022 Condition codes SHALL be: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-023 C=1 SHALL mean no borrow after subtraction, so HI/LS are unsigned compares after x-y.
REQ-024 When taken, res_pc SHALL be br_pc + br_offset modulo 2^nBITS (signed offset, wraps); when not taken, res_pc SHALL be br_pc + 1 modulo 2^nBITS.
REQ-025 res_valid SHALL be 1 only in RESP; res_taken and res_pc SHALL remain stable while res_valid=1 and res_ready=0.
REQ-026 RESP SHALL move to IDLE on an edge where res_ready=1; br_ready SHALL be 1 in the following cycle.
REQ-027 Latency SHALL be: accept at edge T, res_valid=1 from edge T+1 in RESP, i.e. the second cycle after the accept cycle; throughput is at most one branch per 3 cycles.
REQ-028 br_valid while not in IDLE SHALL be ignored; the requester holds the request.

Reset
REQ-029 On reset=1 at an edge, the block SHALL set FSM=IDLE, flags=0000, res_valid=0, res_taken=0 and res_pc=0, discarding any request in flight, in any state.
REQ-030 Reset SHALL take priority over cc_we and over the handshakes; br_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-031 A shared package cc_pkg SHALL hold the cond_e enum (the 16 codes), the state_e enum and the flag bit-index constants.
REQ-032 The block SHALL contain one combinational sub-module, cond_eval (flags, cond -> taken); the PC adder SHALL be inline.

Verification
REQ-033 Bench SHALL check: reset, then flags=0000 and br_ready=1; cond=EQ, pc=0x10, off=0x05 -> res_taken=0, res_pc=0x11.
REQ-034 Bench SHALL check: after 5-5 (flags Z=1,C=1), cond=EQ, pc=0xFE, off=0x04 -> res_taken=1, res_pc=0x02 (wrap-around).
REQ-035 Bench SHALL check: after 0x80-0x01 (V=1,N=0), cond=LT -> res_taken=1; cond=GE -> res_taken=0; after 3-5 (C=0), cond=HI -> res_taken=0.
REQ-036 Bench SHALL check: cc_we with Z=1 in the accept cycle, then Z=0 during EVAL, cond=EQ -> res_taken=1, and flags ends as Z=0.
REQ-037 Bench SHALL check: res_ready held at 0 for 4 cycles -> res_valid, res_pc and res_taken stable and br_ready=0; res_ready=1 -> br_ready=1 the next cycle.
REQ-038 Bench SHALL check: reset asserted in EVAL and in RESP -> res_valid=0 and flags=0 next cycle, with no result emitted.
